// File: rtl/branch_predictor.sv
// -----------------------------------------------------------------------------
// branch_predictor
//
// Next-PC predictor for the fetch stage of the 5-stage pipeline. It replaces
// the fixed PC+INSTSIZE guess with a direct-mapped branch target buffer (BTB)
// and a pattern history table (PHT) of saturating counters. The PHT is indexed
// either by PC bits alone (bimodal, GSHARE = 0) or by PC bits XOR the global
// history register (gshare, GSHARE = 1).
//
// Lookup is purely combinational on pc_FE. Training happens on the rising clock
// edge whenever EX resolves a conditional branch or a JAL. Two saturating
// statistics counters feed the HEX/LEDR debug path.
//
// Ports
//   clk             single clock, all state updates on posedge
//   RESET_N         asynchronous active-low reset
//   pc_FE           current fetch PC
//   pcpred_FE       predicted next PC
//   predtaken_FE    1 when the prediction is a taken redirect
//   ghr_FE          global history snapshot, carried down the pipe to EX
//   upd_valid_EX    EX resolves a branch or JAL this cycle
//   upd_isjmp_EX    resolved instruction is JAL (0 = conditional branch)
//   upd_pc_EX       PC of the resolved instruction
//   upd_taken_EX    actual direction (always 1 for JAL)
//   upd_target_EX   actual taken target
//   upd_ghr_EX      ghr_FE snapshot that travelled with the instruction
//   upd_mispred_EX  EX detected a mispredict (statistics only)
//   cnt_br          number of resolved branches/JALs (saturating)
//   cnt_mispred     number of mispredicts (saturating)
// -----------------------------------------------------------------------------
module branch_predictor #(
  parameter int DBITS     = 32,
  parameter int INDEXBITS = 6,
  parameter int TAGBITS   = 8,
  parameter int CTRBITS   = 2,
  parameter int GSHARE    = 0,
  parameter int CNTBITS   = 16,
  parameter int INSTSIZE  = 4
) (
  input  logic                 clk,
  input  logic                 RESET_N,
  input  logic [DBITS-1:0]     pc_FE,
  output logic [DBITS-1:0]     pcpred_FE,
  output logic                 predtaken_FE,
  output logic [INDEXBITS-1:0] ghr_FE,
  input  logic                 upd_valid_EX,
  input  logic                 upd_isjmp_EX,
  input  logic [DBITS-1:0]     upd_pc_EX,
  input  logic                 upd_taken_EX,
  input  logic [DBITS-1:0]     upd_target_EX,
  input  logic [INDEXBITS-1:0] upd_ghr_EX,
  input  logic                 upd_mispred_EX,
  output logic [CNTBITS-1:0]   cnt_br,
  output logic [CNTBITS-1:0]   cnt_mispred
);

  localparam int ENTRIES = 1 << INDEXBITS;
  localparam int TAGLSB  = INDEXBITS + 2;
  localparam int TAGMSB  = INDEXBITS + TAGBITS + 1;

  localparam logic [CTRBITS-1:0] CTR_MAX  = {CTRBITS{1'b1}};
  localparam logic [CTRBITS-1:0] CTR_MIN  = {CTRBITS{1'b0}};
  localparam logic [CTRBITS-1:0] CTR_ONE  = {{(CTRBITS-1){1'b0}}, 1'b1};
  // Weakly not-taken: MSB clear, all lower bits set (01 for a 2-bit counter).
  localparam logic [CTRBITS-1:0] CTR_INIT = {1'b0, {(CTRBITS-1){1'b1}}};

  localparam logic [CNTBITS-1:0] CNT_MAX  = {CNTBITS{1'b1}};
  localparam logic [CNTBITS-1:0] CNT_ONE  = {{(CNTBITS-1){1'b0}}, 1'b1};
  localparam logic [CNTBITS-1:0] CNT_ZERO = {CNTBITS{1'b0}};

  localparam logic [DBITS-1:0]     PC_INC    = DBITS'(INSTSIZE);
  localparam logic [TAGBITS-1:0]   TAG_ZERO  = {TAGBITS{1'b0}};
  localparam logic [DBITS-1:0]     ADDR_ZERO = {DBITS{1'b0}};
  localparam logic [INDEXBITS-1:0] GHR_ZERO  = {INDEXBITS{1'b0}};

  // Saturating up/down step of a PHT counter.
  function automatic logic [CTRBITS-1:0] ctr_next(input logic [CTRBITS-1:0] ctr,
                                                   input logic              taken);
    logic [CTRBITS-1:0] res;
    res = ctr;
    if (taken) begin
      if (ctr != CTR_MAX) res = ctr + CTR_ONE;
      else                res = ctr;
    end else begin
      if (ctr != CTR_MIN) res = ctr - CTR_ONE;
      else                res = ctr;
    end
    return res;
  endfunction

  // Saturating increment of a statistics counter; never wraps to zero.
  function automatic logic [CNTBITS-1:0] cnt_sat_inc(input logic [CNTBITS-1:0] cnt);
    logic [CNTBITS-1:0] res;
    if (cnt != CNT_MAX) res = cnt + CNT_ONE;
    else                res = cnt;
    return res;
  endfunction

  // ---------------------------------------------------------------------------
  // Storage (all flops with asynchronous clear)
  // ---------------------------------------------------------------------------
  logic [ENTRIES-1:0]   btb_valid_r;
  logic [ENTRIES-1:0]   btb_jmp_r;
  logic [TAGBITS-1:0]   btb_tag_r    [ENTRIES];
  logic [DBITS-1:0]     btb_target_r [ENTRIES];
  logic [CTRBITS-1:0]   pht_r        [ENTRIES];
  logic [INDEXBITS-1:0] ghr_r;
  logic [CNTBITS-1:0]   cnt_br_r;
  logic [CNTBITS-1:0]   cnt_mispred_r;

  // Fetch-side lookup signals
  logic [INDEXBITS-1:0] fe_bidx_s;
  logic [TAGBITS-1:0]   fe_tag_s;
  logic [INDEXBITS-1:0] fe_pidx_s;
  logic                 fe_hit_s;
  logic                 fe_taken_s;
  logic [DBITS-1:0]     fe_pred_s;

  // EX-side update signals
  logic [INDEXBITS-1:0] upd_bidx_s;
  logic [TAGBITS-1:0]   upd_tag_s;
  logic [INDEXBITS-1:0] upd_pidx_s;
  logic                 btb_we_s;
  logic                 pht_we_s;

  // Byte-offset bits and PC bits above the tag never select anything.
  logic unused_upd_pc_bits_s;
  assign unused_upd_pc_bits_s = ^{upd_pc_EX[1:0], upd_pc_EX[DBITS-1:TAGMSB+1]};

  // Combinational lookup on the fetch PC. The lookup reads the stored state
  // directly, so a same-cycle update is only visible from the next cycle on.
  // While RESET_N is low every valid bit is cleared, so the lookup misses and
  // falls through to pc_FE + INSTSIZE without extra gating.
  always_comb begin
    fe_bidx_s = pc_FE[INDEXBITS+1:2];
    fe_tag_s  = pc_FE[TAGMSB:TAGLSB];
    if (GSHARE != 0) begin
      fe_pidx_s = fe_bidx_s ^ ghr_r;
    end else begin
      fe_pidx_s = fe_bidx_s;
    end
    fe_hit_s   = btb_valid_r[fe_bidx_s] && (btb_tag_r[fe_bidx_s] == fe_tag_s);
    fe_taken_s = fe_hit_s && (btb_jmp_r[fe_bidx_s] || pht_r[fe_pidx_s][CTRBITS-1]);
    if (fe_taken_s) begin
      fe_pred_s = btb_target_r[fe_bidx_s];
    end else begin
      fe_pred_s = pc_FE + PC_INC;
    end
  end

  assign pcpred_FE    = fe_pred_s;
  assign predtaken_FE = fe_taken_s;
  assign ghr_FE       = ghr_r;
  assign cnt_br       = cnt_br_r;
  assign cnt_mispred  = cnt_mispred_r;

  // Decode the resolved instruction into table indices and write enables.
  // The PHT index uses the history snapshot taken at fetch time, not the live
  // GHR, so the counter trained is the one that produced the prediction.
  always_comb begin
    upd_bidx_s = upd_pc_EX[INDEXBITS+1:2];
    upd_tag_s  = upd_pc_EX[TAGMSB:TAGLSB];
    if (GSHARE != 0) begin
      upd_pidx_s = upd_bidx_s ^ upd_ghr_EX;
    end else begin
      upd_pidx_s = upd_bidx_s;
    end
    // Only taken outcomes allocate; not-taken branches leave the BTB alone.
    btb_we_s = upd_valid_EX && upd_taken_EX;
    // JALs are always taken and never touch direction state.
    pht_we_s = upd_valid_EX && !upd_isjmp_EX;
  end

  // BTB: allocate/overwrite the direct-mapped entry on every taken outcome.
  always_ff @(posedge clk or negedge RESET_N) begin
    if (!RESET_N) begin
      btb_valid_r <= {ENTRIES{1'b0}};
      btb_jmp_r   <= {ENTRIES{1'b0}};
      for (int i = 0; i < ENTRIES; i++) begin
        btb_tag_r[i]    <= TAG_ZERO;
        btb_target_r[i] <= ADDR_ZERO;
      end
    end else if (btb_we_s) begin
      btb_valid_r[upd_bidx_s]  <= 1'b1;
      btb_jmp_r[upd_bidx_s]    <= upd_isjmp_EX;
      btb_tag_r[upd_bidx_s]    <= upd_tag_s;
      btb_target_r[upd_bidx_s] <= upd_target_EX;
    end
  end

  // PHT: saturating counter training for conditional branches.
  always_ff @(posedge clk or negedge RESET_N) begin
    if (!RESET_N) begin
      for (int i = 0; i < ENTRIES; i++) begin
        pht_r[i] <= CTR_INIT;
      end
    end else if (pht_we_s) begin
      pht_r[upd_pidx_s] <= ctr_next(pht_r[upd_pidx_s], upd_taken_EX);
    end
  end

  // Global history: shift in the outcome of each conditional branch.
  always_ff @(posedge clk or negedge RESET_N) begin
    if (!RESET_N) begin
      ghr_r <= GHR_ZERO;
    end else if (pht_we_s) begin
      ghr_r <= {ghr_r[INDEXBITS-2:0], upd_taken_EX};
    end
  end

  // Statistics: saturating resolved-branch and mispredict counters.
  always_ff @(posedge clk or negedge RESET_N) begin
    if (!RESET_N) begin
      cnt_br_r      <= CNT_ZERO;
      cnt_mispred_r <= CNT_ZERO;
    end else if (upd_valid_EX) begin
      cnt_br_r <= cnt_sat_inc(cnt_br_r);
      if (upd_mispred_EX) begin
        cnt_mispred_r <= cnt_sat_inc(cnt_mispred_r);
      end
    end
  end

endmodule

// File: tb/tb_branch_predictor.sv
// -----------------------------------------------------------------------------
// tb_branch_predictor
//
// Directed bench for branch_predictor. Two instances share clock and reset:
// u_bim (bimodal, GSHARE = 0) and u_gsh (gshare, GSHARE = 1). Inputs change
// 1 ns after a rising edge; outputs are sampled 1 ns after an input change.
// -----------------------------------------------------------------------------
module tb_branch_predictor;

  logic        clk;
  logic        reset_n;

  // Bimodal instance
  logic [31:0] b_pc;
  logic [31:0] b_pred;
  logic        b_taken_fe;
  logic [5:0]  b_ghr;
  logic        b_upd_valid;
  logic        b_upd_isjmp;
  logic [31:0] b_upd_pc;
  logic        b_upd_taken;
  logic [31:0] b_upd_target;
  logic [5:0]  b_upd_ghr;
  logic        b_upd_mispred;
  logic [15:0] b_cnt_br;
  logic [15:0] b_cnt_mis;

  // Gshare instance
  logic [31:0] g_pc;
  logic [31:0] g_pred;
  logic        g_taken_fe;
  logic [5:0]  g_ghr;
  logic        g_upd_valid;
  logic        g_upd_isjmp;
  logic [31:0] g_upd_pc;
  logic        g_upd_taken;
  logic [31:0] g_upd_target;
  logic [5:0]  g_upd_ghr;
  logic        g_upd_mispred;
  logic [15:0] g_cnt_br;
  logic [15:0] g_cnt_mis;

  int checks;
  int failures;

  branch_predictor #(.GSHARE(0)) u_bim (
    .clk            (clk),
    .RESET_N        (reset_n),
    .pc_FE          (b_pc),
    .pcpred_FE      (b_pred),
    .predtaken_FE   (b_taken_fe),
    .ghr_FE         (b_ghr),
    .upd_valid_EX   (b_upd_valid),
    .upd_isjmp_EX   (b_upd_isjmp),
    .upd_pc_EX      (b_upd_pc),
    .upd_taken_EX   (b_upd_taken),
    .upd_target_EX  (b_upd_target),
    .upd_ghr_EX     (b_upd_ghr),
    .upd_mispred_EX (b_upd_mispred),
    .cnt_br         (b_cnt_br),
    .cnt_mispred    (b_cnt_mis)
  );

  branch_predictor #(.GSHARE(1)) u_gsh (
    .clk            (clk),
    .RESET_N        (reset_n),
    .pc_FE          (g_pc),
    .pcpred_FE      (g_pred),
    .predtaken_FE   (g_taken_fe),
    .ghr_FE         (g_ghr),
    .upd_valid_EX   (g_upd_valid),
    .upd_isjmp_EX   (g_upd_isjmp),
    .upd_pc_EX      (g_upd_pc),
    .upd_taken_EX   (g_upd_taken),
    .upd_target_EX  (g_upd_target),
    .upd_ghr_EX     (g_upd_ghr),
    .upd_mispred_EX (g_upd_mispred),
    .cnt_br         (g_cnt_br),
    .cnt_mispred    (g_cnt_mis)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single comparison point: counts every check, reports any mismatch.
  task automatic check_value(input string tag, input logic [31:0] obs,
                             input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic upd_b(input logic [31:0] pc, input logic taken,
                       input logic [31:0] tgt, input logic jmp, input logic mis);
    b_upd_pc      = pc;
    b_upd_taken   = taken;
    b_upd_target  = tgt;
    b_upd_isjmp   = jmp;
    b_upd_ghr     = b_ghr;
    b_upd_mispred = mis;
    b_upd_valid   = 1'b1;
    @(posedge clk);
    #1;
    b_upd_valid   = 1'b0;
  endtask

  task automatic upd_g(input logic [31:0] pc, input logic taken,
                       input logic [31:0] tgt, input logic [5:0] ghr);
    g_upd_pc      = pc;
    g_upd_taken   = taken;
    g_upd_target  = tgt;
    g_upd_isjmp   = 1'b0;
    g_upd_ghr     = ghr;
    g_upd_mispred = 1'b0;
    g_upd_valid   = 1'b1;
    @(posedge clk);
    #1;
    g_upd_valid   = 1'b0;
  endtask

  task automatic look_b(input string tag, input logic [31:0] pc,
                        input logic [31:0] exp_pred, input logic exp_tk);
    b_pc = pc;
    #1;
    check_value({tag, "_pred"}, b_pred, exp_pred);
    check_value({tag, "_taken"}, 32'(b_taken_fe), 32'(exp_tk));
  endtask

  task automatic look_g(input string tag, input logic [31:0] pc,
                        input logic [31:0] exp_pred, input logic exp_tk);
    g_pc = pc;
    #1;
    check_value({tag, "_pred"}, g_pred, exp_pred);
    check_value({tag, "_taken"}, 32'(g_taken_fe), 32'(exp_tk));
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    reset_n  = 1'b0;
    b_pc = 32'h100; b_upd_valid = 1'b0; b_upd_isjmp = 1'b0; b_upd_pc = 32'h0;
    b_upd_taken = 1'b0; b_upd_target = 32'h0; b_upd_ghr = 6'h0; b_upd_mispred = 1'b0;
    g_pc = 32'h100; g_upd_valid = 1'b0; g_upd_isjmp = 1'b0; g_upd_pc = 32'h0;
    g_upd_taken = 1'b0; g_upd_target = 32'h0; g_upd_ghr = 6'h0; g_upd_mispred = 1'b0;

    // ---------------- reset state ----------------
    repeat (2) @(posedge clk);
    #1;
    look_b("rst", 32'h100, 32'h104, 1'b0);
    check_value("rst_cnt_br", 32'(b_cnt_br), 32'h0);
    check_value("rst_cnt_mis", 32'(b_cnt_mis), 32'h0);
    check_value("rst_ghr", 32'(b_ghr), 32'h0);
    reset_n = 1'b1;
    @(posedge clk);
    #1;

    // ---------------- bimodal training ----------------
    upd_b(32'h100, 1'b1, 32'h140, 1'b0, 1'b0);          // ctr 01 -> 10
    look_b("bim_first", 32'h100, 32'h140, 1'b1);
    check_value("bim_cnt_br1", 32'(b_cnt_br), 32'h1);
    for (int i = 0; i < 3; i++) upd_b(32'h100, 1'b1, 32'h140, 1'b0, 1'b0); // -> 11
    upd_b(32'h100, 1'b0, 32'h0, 1'b0, 1'b0);            // -> 10
    look_b("bim_hyst", 32'h100, 32'h140, 1'b1);
    check_value("bim_ghr_ttttn", 32'(b_ghr), 32'h1E);

    // ---------------- JAL and aliasing ----------------
    upd_b(32'h200, 1'b1, 32'h300, 1'b1, 1'b0);          // BTB[0] = JAL, ghr unchanged
    look_b("jal_hit", 32'h200, 32'h300, 1'b1);
    look_b("jal_alias_100", 32'h100, 32'h104, 1'b0);
    check_value("jal_ghr_kept", 32'(b_ghr), 32'h1E);
    for (int i = 0; i < 4; i++) upd_b(32'h400, 1'b0, 32'h0, 1'b0, 1'b0); // pht[0] -> 00
    look_b("jal_after_nt", 32'h200, 32'h300, 1'b1);
    look_b("nt_no_alloc", 32'h400, 32'h404, 1'b0);
    check_value("nt_ghr", 32'(b_ghr), 32'h20);
    upd_b(32'h100, 1'b1, 32'h140, 1'b0, 1'b1);          // pht[0] 00 -> 01 (saturated low)
    look_b("sat_low", 32'h100, 32'h104, 1'b0);
    look_b("alias_200", 32'h200, 32'h204, 1'b0);
    upd_b(32'h200, 1'b1, 32'h280, 1'b0, 1'b0);          // pht[0] -> 10
    look_b("alias_200_tk", 32'h200, 32'h280, 1'b1);
    look_b("alias_100", 32'h100, 32'h104, 1'b0);
    check_value("cnt_br12", 32'(b_cnt_br), 32'd12);
    check_value("cnt_mis1", 32'(b_cnt_mis), 32'd1);

    // ---------------- same-cycle update + lookup (bimodal) ----------------
    b_pc = 32'h104;
    b_upd_pc = 32'h104; b_upd_taken = 1'b1; b_upd_target = 32'h180;
    b_upd_isjmp = 1'b0; b_upd_mispred = 1'b0; b_upd_valid = 1'b1;
    #1;
    check_value("same_cyc_old", b_pred, 32'h108);
    @(posedge clk);
    #1;
    b_upd_valid = 1'b0;
    #1;
    check_value("same_cyc_new", b_pred, 32'h180);

    // ---------------- gshare history separation ----------------
    upd_g(32'h100, 1'b1, 32'h140, 6'h01);               // pht[1] -> 10, ghr -> 000001
    check_value("g_ghr1", 32'(g_ghr), 32'h01);
    look_g("g_hist1", 32'h100, 32'h140, 1'b1);
    for (int i = 0; i < 6; i++) upd_g(32'h3C0, 1'b0, 32'h0, 6'h00); // ghr -> 0
    check_value("g_ghr0", 32'(g_ghr), 32'h00);
    look_g("g_hist0", 32'h100, 32'h104, 1'b0);          // pht[0] untouched (01)
    g_pc = 32'h100;
    g_upd_pc = 32'h100; g_upd_taken = 1'b1; g_upd_target = 32'h180;
    g_upd_ghr = 6'h00; g_upd_isjmp = 1'b0; g_upd_valid = 1'b1;
    #1;
    check_value("g_same_cyc_old", g_pred, 32'h104);
    @(posedge clk);
    #1;
    g_upd_valid = 1'b0;
    #1;
    check_value("g_same_cyc_new", g_pred, 32'h180);

    // ---------------- statistics saturation ----------------
    b_upd_pc = 32'h108; b_upd_taken = 1'b1; b_upd_target = 32'h1C0;
    b_upd_isjmp = 1'b0; b_upd_mispred = 1'b1; b_upd_valid = 1'b1;
    repeat (65539) @(posedge clk);
    #1;
    b_upd_valid = 1'b0;
    check_value("sat_cnt_br", 32'(b_cnt_br), 32'hFFFF);
    check_value("sat_cnt_mis", 32'(b_cnt_mis), 32'hFFFF);
    check_value("sat_ghr", 32'(b_ghr), 32'h3F);
    look_b("pre_rst", 32'h108, 32'h1C0, 1'b1);

    // ---------------- asynchronous reset mid-stream ----------------
    b_upd_valid = 1'b1;
    reset_n = 1'b0;
    #1;
    check_value("arst_cnt_br", 32'(b_cnt_br), 32'h0);
    check_value("arst_cnt_mis", 32'(b_cnt_mis), 32'h0);
    check_value("arst_ghr", 32'(b_ghr), 32'h0);
    check_value("arst_pred", b_pred, 32'h10C);
    check_value("arst_taken", 32'(b_taken_fe), 32'h0);
    repeat (2) @(posedge clk);
    #1;
    b_upd_valid = 1'b0;
    reset_n = 1'b1;
    #1;
    check_value("rst_discard_cnt", 32'(b_cnt_br), 32'h0);
    look_b("rst_discard_btb", 32'h108, 32'h10C, 1'b0);
    // PHT must be back at weakly not-taken: T then NT ends not-taken.
    upd_b(32'h108, 1'b1, 32'h1C0, 1'b0, 1'b0);
    look_b("pht_init_t", 32'h108, 32'h1C0, 1'b1);
    upd_b(32'h108, 1'b0, 32'h0, 1'b0, 1'b0);
    look_b("pht_init_nt", 32'h108, 32'h10C, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/branch_predictor.md
Name: branch_predictor

Overview:
- Parametrised next-PC predictor for the 5-stage pipeline's fetch stage. It replaces the fixed PC+4 prediction.
- Contains a direct-mapped branch target buffer (BTB) and a pattern history table (PHT) of saturating counters. The PHT runs in bimodal or gshare mode.
- Lookup is combinational on the fetch PC. Training happens on the clock edge when EX resolves a branch or JAL.
- Also keeps branch and mispredict statistics counters for the HEX/LEDR debug path.

Parameters:
- DBITS, 32, address/data width.
- INDEXBITS, 6, log2 of BTB/PHT entries (64).
- TAGBITS, 8, BTB tag width.
- CTRBITS, 2, PHT counter width.
- GSHARE, 0, 0 = PHT index is PC bits only; 1 = PC bits XOR global history.
- CNTBITS, 16, width of statistics counters.
- INSTSIZE, 4, fall-through increment.

Ports:
- clk  in  1  single clock, all state on posedge.
- RESET_N  in  1  asynchronous, active-low reset.
- pc_FE  in  DBITS  current fetch PC.
- pcpred_FE  out  DBITS  predicted next PC.
- predtaken_FE  out  1  prediction is a taken redirect.
- ghr_FE  out  INDEXBITS  history snapshot; pipeline carries it to EX.
- upd_valid_EX  in  1  EX is resolving a branch or JAL this cycle.
- upd_isjmp_EX  in  1  resolved instruction is JAL (0 = conditional branch).
- upd_pc_EX  in  DBITS  PC of the resolved instruction.
- upd_taken_EX  in  1  actual direction (JAL is always 1).
- upd_target_EX  in  DBITS  actual taken target.
- upd_ghr_EX  in  INDEXBITS  ghr_FE snapshot carried from fetch.
- upd_mispred_EX  in  1  EX detected a mispredict (statistics only).
- cnt_br  out  CNTBITS  resolved branch/JAL count.
- cnt_mispred  out  CNTBITS  mispredict count.

Behaviour:
- Field split of a PC: bidx = pc[INDEXBITS+1:2]; tag = pc[INDEXBITS+TAGBITS+1:INDEXBITS+2].
- PHT index: pidx = GSHARE ? (bidx ^ ghr) : bidx.
- Lookup (0-cycle, combinational):
  - hit = btb_valid[bidx] and btb_tag[bidx] == tag(pc_FE).
  - predtaken_FE = hit and (btb_jmp[bidx] or pht[pidx][CTRBITS-1]).
  - pcpred_FE = predtaken_FE ? btb_target[bidx] : pc_FE + INSTSIZE.
  - ghr_FE = current ghr.
- Update (posedge, only when upd_valid_EX = 1; all indices use upd_pc_EX):
  - BTB: on upd_taken_EX = 1, write entry at bidx with valid = 1, tag, target = upd_target_EX, jmp = upd_isjmp_EX. This overwrites any alias.
  - BTB: on not-taken, the entry is left unchanged; no allocation.
  - PHT: only when upd_isjmp_EX = 0. Index with upd_ghr_EX (not the live ghr).
  - PHT counter: increment if taken, decrement if not. Saturate at 0 and 2^CTRBITS-1.
  - GHR: only for conditional branches, ghr <= {ghr[INDEXBITS-2:0], upd_taken_EX}. JAL does not shift the history.
  - GHR is maintained but unused for indexing when GSHARE = 0.
  - cnt_br += 1 per update. cnt_mispred += 1 when upd_mispred_EX = 1. Both saturate at all-ones and never wrap.
- Same-cycle lookup and update on the same entry: lookup sees pre-update contents; the new value is visible the next cycle.
- PC bits [1:0] are ignored.
- Reset (RESET_N low, asynchronous, any time including mid-training):
  - all btb_valid = 0; every PHT counter = weakly not-taken (2^(CTRBITS-1) - 1, i.e. 01 for 2 bits).
  - ghr = 0; cnt_br = cnt_mispred = 0.
  - Outputs while in reset: predtaken_FE = 0, pcpred_FE = pc_FE + INSTSIZE.
- Updates arriving while RESET_N is low are discarded.
- Implement the storage as flops with asynchronous clear; no RAM macros.

Test Plan:
- Reset, pc_FE = 0x100 -> pcpred_FE = 0x104, predtaken_FE = 0, cnt_br = 0.
- Bimodal taken training: one update with pc 0x100, taken, target 0x140, isjmp = 0.
  - Next cycle, pc_FE = 0x100 -> counter 10, pcpred_FE = 0x140, predtaken_FE = 1.
  - Then 3 more taken updates and 1 not-taken update -> counter 10, prediction still 0x140.
- JAL: one update with pc 0x200, target 0x300, isjmp = 1 -> pc_FE = 0x200 predicts 0x300.
  - Then 4 not-taken branch updates at another PC with the same pidx -> JAL still predicts 0x300.
- Alias: train pc 0x100 taken -> 0x140, then lookup pc 0x200 (same bidx, different tag) -> miss, pcpred_FE = 0x204.
  - Train 0x200 taken -> 0x280 -> lookup 0x100 now misses.
- GSHARE = 1 with history 0b000001 vs 0b000000: the same PC uses different counters.
  - Training under one history leaves the other's prediction untouched.
  - The same-cycle update plus lookup returns the old value.
- Statistics: force 2^CNTBITS + 3 updates with upd_mispred_EX = 1 -> both counters hold all-ones.
  - Assert RESET_N low mid-stream -> counters, BTB and GHR clear immediately, with no clock required.
